// File: rtl/ckpt_rat_pkg.sv
// Shared widths, the rename-table entry type and the retire-clear rule used
// by both the live table and the checkpoint copies.
package ckpt_rat_pkg;

    localparam int unsigned AREG_W       = 5;
    localparam int unsigned NUM_AREG_DEF = 32;
    localparam int unsigned ROB_SIZE_DEF = 32;
    localparam int unsigned NUM_CKPT_DEF = 4;
    localparam int unsigned TAG_W        = $clog2(ROB_SIZE_DEF);
    localparam int unsigned CK_W         = $clog2(NUM_CKPT_DEF);

    typedef struct packed {
        logic             is_prf;
        logic [TAG_W-1:0] tag;
    } rat_entry_t;

    // A retiring producer returns its register to the PRF only if the entry
    // still points at that very ROB slot.
    function automatic rat_entry_t retire_clear(
        input rat_entry_t        e,
        input logic [AREG_W-1:0] areg,
        input logic              val,
        input logic [AREG_W-1:0] rd,
        input logic [TAG_W-1:0]  rob
    );
        rat_entry_t r;
        r = e;
        if (val && (rd == areg) && !e.is_prf && (e.tag == rob)) begin
            r.is_prf = 1'b1;
            r.tag    = TAG_W'(areg);
        end
        return r;
    endfunction

endpackage

// File: rtl/rat_ckpt_buf.sv
// Circular buffer of rename-table checkpoints: allocation at tail, release
// at head, restore read-out for mispredict recovery, retire clears on copies.
module rat_ckpt_buf
    import ckpt_rat_pkg::*;
#(
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned RET_W    = 2,
    parameter int unsigned NUM_AREG = NUM_AREG_DEF,
    parameter int unsigned NUM_CKPT = NUM_CKPT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         accept,
    input  logic [ISSUE_W-1:0]           br_req,
    input  rat_entry_t                   snap [ISSUE_W][NUM_AREG],
    input  logic                         ckpt_release,
    input  logic                         flush_val,
    input  logic [CK_W-1:0]              flush_ckpt,
    input  logic [RET_W-1:0]             val_ret,
    input  logic [RET_W-1:0][AREG_W-1:0] rd_ret,
    input  logic [RET_W-1:0][TAG_W-1:0]  robid_ret,
    output logic [CK_W-1:0]              alloc_id_c [ISSUE_W],
    output logic [CK_W:0]                free_cnt_c,
    output rat_entry_t                   restore_c [NUM_AREG]
);

    localparam int unsigned CNT_W = CK_W + 1;

    logic [CK_W-1:0]  head;
    logic [CK_W-1:0]  tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] n_alloc;
    logic             rel;
    rat_entry_t       ck_data [NUM_CKPT][NUM_AREG];
    rat_entry_t       ck_nxt  [NUM_CKPT][NUM_AREG];

    // Consecutive ids per branch in slot order; counters for pointer update.
    always_comb begin
        n_alloc = '0;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            alloc_id_c[i] = tail + CK_W'(n_alloc);
            if (br_req[i]) n_alloc = n_alloc + CNT_W'(1);
        end
        if (!accept) n_alloc = '0;
        rel        = ckpt_release && (count != '0);
        free_cnt_c = CNT_W'(NUM_CKPT) - count;
    end

    always_comb begin
        for (int r = 0; r < int'(NUM_AREG); r++) begin
            restore_c[r] = ck_data[flush_ckpt][r];
        end
    end

    // Retire clears apply to every copy first; a fresh snapshot overrides.
    always_comb begin
        for (int c = 0; c < int'(NUM_CKPT); c++) begin
            for (int r = 0; r < int'(NUM_AREG); r++) begin
                ck_nxt[c][r] = ck_data[c][r];
                for (int k = 0; k < int'(RET_W); k++) begin
                    ck_nxt[c][r] = retire_clear(ck_nxt[c][r], AREG_W'(r),
                                                val_ret[k], rd_ret[k], robid_ret[k]);
                end
            end
        end
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            if (accept && br_req[i]) begin
                for (int r = 0; r < int'(NUM_AREG); r++) begin
                    ck_nxt[alloc_id_c[i]][r] = snap[i][r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        ck_data <= ck_nxt;
    end

    // Liveness is carried by the pointers alone, so reset kills every copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head + CK_W'(rel);
            if (flush_val) begin
                tail  <= flush_ckpt + CK_W'(1);
                count <= CNT_W'(CK_W'(flush_ckpt - head)) + CNT_W'(1) - CNT_W'(rel);
            end else begin
                tail  <= tail + CK_W'(n_alloc);
                count <= count + n_alloc - CNT_W'(rel);
            end
        end
    end

endmodule

// File: rtl/ckpt_rat.sv
// Register alias table with branch checkpoints: renames a group of sources,
// records destination ROB ids, and restores the table on a mispredict.
module ckpt_rat
    import ckpt_rat_pkg::*;
#(
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned RET_W    = 2,
    parameter int unsigned NUM_AREG = NUM_AREG_DEF,
    parameter int unsigned ROB_SIZE = ROB_SIZE_DEF,
    parameter int unsigned NUM_CKPT = NUM_CKPT_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ISSUE_W-1:0]                 instr_val_id,
    input  logic [ISSUE_W-1:0][AREG_W-1:0]     rd_id,
    input  logic [ISSUE_W-1:0][AREG_W-1:0]     rs1_id,
    input  logic [ISSUE_W-1:0][AREG_W-1:0]     rs2_id,
    input  logic [ISSUE_W-1:0]                 wr_rd_id,
    input  logic [ISSUE_W-1:0]                 is_br_id,
    input  logic [TAG_W-1:0]                   rob_is_ptr,
    input  logic                               rob_full,
    input  logic [RET_W-1:0]                   val_ret,
    input  logic [RET_W-1:0][AREG_W-1:0]       rd_ret,
    input  logic [RET_W-1:0][TAG_W-1:0]        robid_ret,
    input  logic                               ckpt_release,
    input  logic                               flush_val,
    input  logic [CK_W-1:0]                    flush_ckpt,
    output logic                               rename_rdy,
    output logic [ISSUE_W-1:0][1:0][TAG_W-1:0] src_tag_ar,
    output logic [ISSUE_W-1:0][1:0]            src_is_prf_ar,
    output logic [ISSUE_W-1:0][TAG_W-1:0]      robid_ar,
    output logic [ISSUE_W-1:0][CK_W-1:0]       ckpt_id_ar,
    output logic [ISSUE_W-1:0]                 val_ar
);

    localparam int unsigned CNT_W = CK_W + 1;

    rat_entry_t         tbl      [NUM_AREG];
    rat_entry_t         stage    [ISSUE_W+1][NUM_AREG];
    rat_entry_t         snap     [ISSUE_W][NUM_AREG];
    rat_entry_t         restore_c[NUM_AREG];
    rat_entry_t         src_nxt  [ISSUE_W][2];
    logic [TAG_W-1:0]   slot_rob [ISSUE_W];
    logic [CK_W-1:0]    alloc_id_c [ISSUE_W];
    logic [CK_W:0]      free_cnt_c;
    logic [CNT_W-1:0]   br_cnt;
    logic [ISSUE_W-1:0] br_req;

    always_comb begin
        br_cnt = '0;
        br_req = instr_val_id & is_br_id;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            slot_rob[i] = TAG_W'((int'(rob_is_ptr) + i) % int'(ROB_SIZE));
            if (br_req[i]) br_cnt = br_cnt + CNT_W'(1);
        end
        rename_rdy = !rob_full && !flush_val && (br_cnt <= free_cnt_c);
    end

    // stage[i] is the table as branch slot i must see it: retire clears plus
    // all older-slot writes; stage[ISSUE_W] is the next table.
    always_comb begin
        for (int r = 0; r < int'(NUM_AREG); r++) begin
            stage[0][r] = flush_val ? restore_c[r] : tbl[r];
            for (int k = 0; k < int'(RET_W); k++) begin
                stage[0][r] = retire_clear(stage[0][r], AREG_W'(r),
                                           val_ret[k], rd_ret[k], robid_ret[k]);
            end
        end
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            stage[i+1] = stage[i];
            snap[i]    = stage[i];
            if (rename_rdy && instr_val_id[i] && wr_rd_id[i] && (rd_id[i] != '0)) begin
                stage[i+1][rd_id[i]] = '{is_prf: 1'b0, tag: slot_rob[i]};
            end
        end
    end

    // Source lookup: table, then retire override, then in-group bypass, then x0.
    always_comb begin
        logic [AREG_W-1:0] src;
        rat_entry_t        e;
        src = '0;
        e   = '0;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            for (int s = 0; s < 2; s++) begin
                src = (s == 0) ? rs1_id[i] : rs2_id[i];
                e   = tbl[src];
                if (!e.is_prf) begin
                    for (int k = 0; k < int'(RET_W); k++) begin
                        if (val_ret[k] && (robid_ret[k] == e.tag)) begin
                            e = '{is_prf: 1'b1, tag: TAG_W'(src)};
                        end
                    end
                end
                for (int j = 0; j < i; j++) begin
                    if (instr_val_id[j] && wr_rd_id[j] && (rd_id[j] == src)) begin
                        e = '{is_prf: 1'b0, tag: slot_rob[j]};
                    end
                end
                if (src == '0) e = '{is_prf: 1'b1, tag: '0};
                src_nxt[i][s] = e;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(NUM_AREG); r++) begin
                tbl[r] <= '{is_prf: 1'b1, tag: TAG_W'(r)};
            end
        end else begin
            tbl <= stage[ISSUE_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_tag_ar    <= '0;
            src_is_prf_ar <= '0;
            robid_ar      <= '0;
            ckpt_id_ar    <= '0;
            val_ar        <= '0;
        end else begin
            val_ar <= instr_val_id & {ISSUE_W{rename_rdy}};
            if (rename_rdy) begin
                for (int i = 0; i < int'(ISSUE_W); i++) begin
                    for (int s = 0; s < 2; s++) begin
                        src_tag_ar[i][s]    <= src_nxt[i][s].tag;
                        src_is_prf_ar[i][s] <= src_nxt[i][s].is_prf;
                    end
                    robid_ar[i]   <= slot_rob[i];
                    ckpt_id_ar[i] <= alloc_id_c[i];
                end
            end
        end
    end

    rat_ckpt_buf #(
        .ISSUE_W  (ISSUE_W),
        .RET_W    (RET_W),
        .NUM_AREG (NUM_AREG),
        .NUM_CKPT (NUM_CKPT)
    ) u_ckpt_buf (
        .clk          (clk),
        .rst          (rst),
        .accept       (rename_rdy),
        .br_req       (br_req),
        .snap         (snap),
        .ckpt_release (ckpt_release),
        .flush_val    (flush_val),
        .flush_ckpt   (flush_ckpt),
        .val_ret      (val_ret),
        .rd_ret       (rd_ret),
        .robid_ret    (robid_ret),
        .alloc_id_c   (alloc_id_c),
        .free_cnt_c   (free_cnt_c),
        .restore_c    (restore_c)
    );

endmodule

// File: doc/ckpt_rat.md
CKPT_RAT -- requirements
Module: ckpt_rat

Interface
REQ-001 SHALL provide parameter ISSUE_W, default 2, rename slots per cycle.
REQ-002 SHALL provide parameter RET_W, default 2, retire ports per cycle.
REQ-003 SHALL provide parameter NUM_AREG, default 32, architectural registers; x0 never renamed.
REQ-004 SHALL provide parameter ROB_SIZE, default 32, power of two; TAG_W = $clog2(ROB_SIZE).
REQ-005 SHALL provide parameter NUM_CKPT, default 4, branch checkpoints; CK_W = $clog2(NUM_CKPT).
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 instr_val_id  in  ISSUE_W  slot valid; slot 0 oldest.
REQ-009 rd_id, rs1_id, rs2_id  in  ISSUE_W x 5  register indices.
REQ-010 wr_rd_id  in  ISSUE_W  slot writes rd (not store or branch).
REQ-011 is_br_id  in  ISSUE_W  slot is a branch needing a checkpoint.
REQ-012 rob_is_ptr  in  TAG_W  ROB id of slot 0; slot i gets rob_is_ptr+i mod ROB_SIZE.
REQ-013 rob_full  in  1  ROB cannot accept the group.
REQ-014 val_ret, rd_ret, robid_ret  in  RET_W, RET_W x 5, RET_W x TAG_W  retire bus; rd-writing retires only.
REQ-015 ckpt_release  in  1  oldest branch retired; frees oldest checkpoint.
REQ-016 flush_val, flush_ckpt  in  1, CK_W  mispredict; restore from checkpoint flush_ckpt.
REQ-017 rename_rdy  out  1  group accepted this cycle.
REQ-018 src_tag_ar  out  ISSUE_W x 2 x TAG_W  renamed rs1/rs2 (register index when PRF).
REQ-019 src_is_prf_ar  out  ISSUE_W x 2  1: PRF, 0: ROB.
REQ-020 robid_ar, ckpt_id_ar, val_ar  out  ISSUE_W x TAG_W, ISSUE_W x CK_W, ISSUE_W  per-slot ROB id, checkpoint id, output valid.

Function
REQ-021 rename_rdy SHALL be ~rob_full & ~flush_val & (branch count in group <= free checkpoints); combinational.
REQ-022 Outputs SHALL be registered, latency 1 cycle; val_ar[i] = instr_val_id[i] & rename_rdy of previous cycle; other outputs hold when not accepted.
REQ-023 Each source SHALL read the table, then bypass from the youngest older slot j<i in the group with wr_rd_id[j] & rd_id[j]==src -> ROB, tag rob_is_ptr+j.
REQ-024 Retirement override: source from table with ROB tag equal to a valid robid_ret in the same cycle SHALL output PRF, tag = register index.
REQ-025 Source x0 SHALL always output PRF, tag 0.
REQ-026 On accept, each slot with wr_rd_id & rd!=0 SHALL write entry rd := ROB, rob_is_ptr+i; youngest slot wins on equal rd.
REQ-027 Retire port k SHALL set entry rd_ret[k] to PRF only if entry is ROB with tag == robid_ret[k]; same-cycle issue write to that rd wins.
REQ-028 Branch slot i SHALL allocate checkpoint at tail, snapshot = table after older-slot writes j<i and same-cycle retire clears; ckpt_id_ar[i] = allocated id.
REQ-029 Checkpoints SHALL be a circular buffer (head, tail, count); several branches per group allocate consecutive ids, wrapping mod NUM_CKPT.
REQ-030 Live checkpoints SHALL apply the retire clear rule of REQ-027 to their own copies.
REQ-031 ckpt_release SHALL free head; ignored when count==0.
REQ-032 flush_val SHALL copy checkpoint flush_ckpt into table, set tail := flush_ckpt+1, free all younger, clear val_ar next cycle; same-cycle retires apply to restored data; same-cycle ckpt_release still frees head.
REQ-033 Issue writes SHALL be suppressed when rename_rdy=0.

Reset
REQ-034 On rst low: entry r := PRF, tag r; head=tail=count=0; all outputs 0; takes effect immediately, no clock needed.
REQ-035 Reset mid-flush or mid-allocation SHALL leave no partial checkpoint live.

Structure
REQ-036 rat_entry_t {is_prf, tag} and TAG_W, CK_W SHALL reside in the shared constants package.
REQ-037 Checkpoint storage, pointers and retire-clear SHALL be sub-module rat_ckpt_buf.

Verification
REQ-038 After reset, rs1=5, rs2=0 -> PRF tag 5, PRF tag 0.
REQ-039 Group {rd=3, rs1=3 in slot1}, rob_is_ptr=31 -> slot1 rs1 ROB tag 31; entry 3 = ROB 31; slot1 robid 0 (wrap).
REQ-040 Both slots rd=7, ptr=4 -> entry 7 = ROB 5; retire robid 4 rd 7 -> entry stays ROB 5.
REQ-041 Branch at slot1 after slot0 rd=2 (ROB 10), then rd=2 -> ROB 12, flush ckpt 0 -> rs1=2 reads ROB 10.
REQ-042 4 live checkpoints, group with branch -> rename_rdy=0; ckpt_release same cycle -> accepted next cycle.
REQ-043 Retire robid 10 rd 2 in the same cycle as source lookup of x2 -> PRF tag 2.
